// File: rtl/cdb_complete_arbiter_pkg.sv
// Shared definitions for the CDB complete stage.
// Contents:
//   XLEN, ROBLEN       datapath width and ROB depth
//   NUM_FU_DEF, CDB_W_DEF, TAG_W_DEF  default top-level parameters
//   fu_result_t        one finished FU result (tag, value, NPC, taken)
//   cdb_packet_t       one CDB broadcast slot (valid + fu_result fields)
//   ptr_width()        index width for an n-entry vector (never below 1)
package cdb_complete_arbiter_pkg;

    localparam int XLEN       = 32;
    localparam int ROBLEN     = 32;
    localparam int TAG_W_DEF  = $clog2(ROBLEN);
    localparam int NUM_FU_DEF = 4;
    localparam int CDB_W_DEF  = 2;

    typedef struct packed {
        logic [TAG_W_DEF-1:0] tag;
        logic [XLEN-1:0]      value;
        logic [XLEN-1:0]      npc;
        logic                 taken;
    } fu_result_t;

    typedef struct packed {
        logic                 valid;
        logic [TAG_W_DEF-1:0] tag;
        logic [XLEN-1:0]      value;
        logic [XLEN-1:0]      npc;
        logic                 taken;
    } cdb_packet_t;

    function automatic int ptr_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/cdb_complete_arbiter_select.sv
// Round-robin multi-grant selector (purely combinational).
// Picks up to CDB_W requesters, scanning from start upward and wrapping.
// Ports:
//   req        in   NUM_FU          request vector
//   start      in   PTR_W           first index scanned
//   grant      out  NUM_FU          granted requesters
//   slot_valid out  CDB_W           slot k received a grant
//   slot_idx   out  CDB_W x PTR_W   FU index driving slot k
//   last_idx   out  PTR_W           last granted index (start when none)
module cdb_complete_arbiter_select #(
    parameter int NUM_FU = 4,
    parameter int CDB_W  = 2,
    parameter int PTR_W  = 2
) (
    input  logic [NUM_FU-1:0]           req,
    input  logic [PTR_W-1:0]            start,
    output logic [NUM_FU-1:0]           grant,
    output logic [CDB_W-1:0]            slot_valid,
    output logic [CDB_W-1:0][PTR_W-1:0] slot_idx,
    output logic [PTR_W-1:0]            last_idx
);

    localparam logic [PTR_W:0] NUM_FU_W = (PTR_W+1)'(NUM_FU);

    // One priority pick per slot; requesters already granted to an earlier
    // slot are masked out, so slot order follows the rotated scan order.
    always_comb begin
        logic           found;
        logic [PTR_W:0] sum;
        logic [PTR_W-1:0] idx;
        grant      = '0;
        slot_valid = '0;
        slot_idx   = '0;
        last_idx   = start;
        found      = 1'b0;
        sum        = '0;
        idx        = '0;
        for (int k = 0; k < CDB_W; k++) begin
            found = 1'b0;
            for (int o = 0; o < NUM_FU; o++) begin
                sum = {1'b0, start} + (PTR_W+1)'(o);
                if (sum >= NUM_FU_W) begin
                    sum = sum - NUM_FU_W;
                end
                idx = sum[PTR_W-1:0];
                if (!found && req[idx] && !grant[idx]) begin
                    found         = 1'b1;
                    grant[idx]    = 1'b1;
                    slot_valid[k] = 1'b1;
                    slot_idx[k]   = idx;
                    last_idx      = idx;
                end
            end
        end
    end

endmodule

// File: rtl/cdb_complete_arbiter.sv
// Complete stage: one holding entry per FU, round-robin selection of up to
// CDB_W results per cycle onto registered CDB slots.
// Optional feature macro: CDB_BYPASS_EN (an incoming result into an empty
// entry may be granted in its arrival cycle without passing through hold).
// Ports:
//   clock, reset (async active-low), clear (sync squash, active-high)
//   fu_valid/fu_tag/fu_result/fu_npc/fu_taken   per-FU result inputs
//   fu_ready                                     per-FU accept (combinational)
//   cdb_valid/cdb_tag/cdb_value/cdb_npc/cdb_taken registered CDB slots
module cdb_complete_arbiter
    import cdb_complete_arbiter_pkg::*;
#(
    parameter int NUM_FU = NUM_FU_DEF,
    parameter int CDB_W  = CDB_W_DEF,
    parameter int TAG_W  = TAG_W_DEF
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    clear,
    input  logic [NUM_FU-1:0]       fu_valid,
    input  logic [NUM_FU*TAG_W-1:0] fu_tag,
    input  logic [NUM_FU*XLEN-1:0]  fu_result,
    input  logic [NUM_FU*XLEN-1:0]  fu_npc,
    input  logic [NUM_FU-1:0]       fu_taken,
    output logic [NUM_FU-1:0]       fu_ready,
    output logic [CDB_W-1:0]        cdb_valid,
    output logic [CDB_W*TAG_W-1:0]  cdb_tag,
    output logic [CDB_W*XLEN-1:0]   cdb_value,
    output logic [CDB_W*XLEN-1:0]   cdb_npc,
    output logic [CDB_W-1:0]        cdb_taken
);

    localparam int PTR_W = ptr_width(NUM_FU);
    localparam logic [PTR_W-1:0] LAST_FU = PTR_W'(NUM_FU - 1);

    logic [NUM_FU-1:0] hold_valid_reg;
    logic [TAG_W-1:0]  hold_tag_reg   [NUM_FU];
    logic [XLEN-1:0]   hold_value_reg [NUM_FU];
    logic [XLEN-1:0]   hold_npc_reg   [NUM_FU];
    logic [NUM_FU-1:0] hold_taken_reg;
    logic [PTR_W-1:0]  rr_ptr_reg;
    logic [PTR_W-1:0]  rr_ptr_next;

    logic [TAG_W-1:0]  in_tag   [NUM_FU];
    logic [XLEN-1:0]   in_value [NUM_FU];
    logic [XLEN-1:0]   in_npc   [NUM_FU];
    logic [TAG_W-1:0]  src_tag   [NUM_FU];
    logic [XLEN-1:0]   src_value [NUM_FU];
    logic [XLEN-1:0]   src_npc   [NUM_FU];
    logic [NUM_FU-1:0] src_taken;
    logic [NUM_FU-1:0] cand;
    logic [NUM_FU-1:0] grant;
    logic [NUM_FU-1:0] bypass_take;
    logic [NUM_FU-1:0] load;

    logic [CDB_W-1:0]            slot_valid;
    logic [CDB_W-1:0][PTR_W-1:0] slot_idx;
    logic [PTR_W-1:0]            last_idx;

    logic [CDB_W-1:0] cdb_valid_reg;
    logic [TAG_W-1:0] cdb_tag_reg   [CDB_W];
    logic [XLEN-1:0]  cdb_value_reg [CDB_W];
    logic [XLEN-1:0]  cdb_npc_reg   [CDB_W];
    logic [CDB_W-1:0] cdb_taken_reg;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_FU; gi++) begin : g_fu
            assign in_tag[gi]   = fu_tag[gi*TAG_W +: TAG_W];
            assign in_value[gi] = fu_result[gi*XLEN +: XLEN];
            assign in_npc[gi]   = fu_npc[gi*XLEN +: XLEN];
`ifdef CDB_BYPASS_EN
            // An empty entry with a fresh result competes with the input
            // itself; an occupied entry always competes with its held copy.
            assign cand[gi]        = hold_valid_reg[gi] | fu_valid[gi];
            assign bypass_take[gi] = grant[gi] & ~hold_valid_reg[gi];
            assign src_tag[gi]     = hold_valid_reg[gi] ? hold_tag_reg[gi]   : in_tag[gi];
            assign src_value[gi]   = hold_valid_reg[gi] ? hold_value_reg[gi] : in_value[gi];
            assign src_npc[gi]     = hold_valid_reg[gi] ? hold_npc_reg[gi]   : in_npc[gi];
            assign src_taken[gi]   = hold_valid_reg[gi] ? hold_taken_reg[gi] : fu_taken[gi];
`else
            assign cand[gi]        = hold_valid_reg[gi];
            assign bypass_take[gi] = 1'b0;
            assign src_tag[gi]     = hold_tag_reg[gi];
            assign src_value[gi]   = hold_value_reg[gi];
            assign src_npc[gi]     = hold_npc_reg[gi];
            assign src_taken[gi]   = hold_taken_reg[gi];
`endif
            // A granted entry drains this edge, so it can refill at once.
            assign fu_ready[gi] = ~clear & (~hold_valid_reg[gi] | grant[gi]);
            assign load[gi]     = fu_valid[gi] & fu_ready[gi] & ~bypass_take[gi];
        end

        for (gi = 0; gi < CDB_W; gi++) begin : g_slot
            assign cdb_tag[gi*TAG_W +: TAG_W]  = cdb_tag_reg[gi];
            assign cdb_value[gi*XLEN +: XLEN]  = cdb_value_reg[gi];
            assign cdb_npc[gi*XLEN +: XLEN]    = cdb_npc_reg[gi];
        end
    endgenerate

    assign cdb_valid = cdb_valid_reg;
    assign cdb_taken = cdb_taken_reg;

    cdb_complete_arbiter_select #(
        .NUM_FU (NUM_FU),
        .CDB_W  (CDB_W),
        .PTR_W  (PTR_W)
    ) u_select (
        .req        (cand),
        .start      (rr_ptr_reg),
        .grant      (grant),
        .slot_valid (slot_valid),
        .slot_idx   (slot_idx),
        .last_idx   (last_idx)
    );

    assign rr_ptr_next = (last_idx == LAST_FU) ? '0 : last_idx + PTR_W'(1);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            hold_valid_reg <= '0;
            hold_taken_reg <= '0;
            for (int i = 0; i < NUM_FU; i++) begin
                hold_tag_reg[i]   <= '0;
                hold_value_reg[i] <= '0;
                hold_npc_reg[i]   <= '0;
            end
        end else if (clear) begin
            hold_valid_reg <= '0;
        end else begin
            for (int i = 0; i < NUM_FU; i++) begin
                if (load[i]) begin
                    hold_valid_reg[i] <= 1'b1;
                    hold_tag_reg[i]   <= in_tag[i];
                    hold_value_reg[i] <= in_value[i];
                    hold_npc_reg[i]   <= in_npc[i];
                    hold_taken_reg[i] <= fu_taken[i];
                end else if (grant[i]) begin
                    hold_valid_reg[i] <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rr_ptr_reg <= '0;
        end else if (!clear && (|grant)) begin
            rr_ptr_reg <= rr_ptr_next;
        end
    end

    // Idle and squashed slots are driven to zero so downstream sees clean data.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cdb_valid_reg <= '0;
            cdb_taken_reg <= '0;
            for (int k = 0; k < CDB_W; k++) begin
                cdb_tag_reg[k]   <= '0;
                cdb_value_reg[k] <= '0;
                cdb_npc_reg[k]   <= '0;
            end
        end else begin
            for (int k = 0; k < CDB_W; k++) begin
                if (!clear && slot_valid[k]) begin
                    cdb_valid_reg[k] <= 1'b1;
                    cdb_tag_reg[k]   <= src_tag[slot_idx[k]];
                    cdb_value_reg[k] <= src_value[slot_idx[k]];
                    cdb_npc_reg[k]   <= src_npc[slot_idx[k]];
                    cdb_taken_reg[k] <= src_taken[slot_idx[k]];
                end else begin
                    cdb_valid_reg[k] <= 1'b0;
                    cdb_tag_reg[k]   <= '0;
                    cdb_value_reg[k] <= '0;
                    cdb_npc_reg[k]   <= '0;
                    cdb_taken_reg[k] <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_cdb_complete_arbiter.sv
// Directed bench for cdb_complete_arbiter (default build, no bypass).
// dut drives the 2-slot CDB; dut1 shares the inputs with a single slot and
// is observed only in the fairness sequence.
module tb_cdb_complete_arbiter;
    localparam int NF = 4;
    localparam int TW = 5;
    localparam int XW = 32;

    logic              clock;
    logic              reset;
    logic              clear;
    logic [NF-1:0]     fu_valid;
    logic [NF*TW-1:0]  fu_tag;
    logic [NF*XW-1:0]  fu_result;
    logic [NF*XW-1:0]  fu_npc;
    logic [NF-1:0]     fu_taken;
    logic [NF-1:0]     fu_ready;
    logic [1:0]        cdb_valid;
    logic [2*TW-1:0]   cdb_tag;
    logic [2*XW-1:0]   cdb_value;
    logic [2*XW-1:0]   cdb_npc;
    logic [1:0]        cdb_taken;
    logic [NF-1:0]     fu_ready_1;
    logic [0:0]        cdb_valid_1;
    logic [TW-1:0]     cdb_tag_1;
    logic [XW-1:0]     cdb_value_1;
    logic [XW-1:0]     cdb_npc_1;
    logic [0:0]        cdb_taken_1;

    int checks = 0;
    int errors = 0;

    cdb_complete_arbiter #(.NUM_FU(NF), .CDB_W(2), .TAG_W(TW)) dut (
        .clock(clock), .reset(reset), .clear(clear),
        .fu_valid(fu_valid), .fu_tag(fu_tag), .fu_result(fu_result),
        .fu_npc(fu_npc), .fu_taken(fu_taken), .fu_ready(fu_ready),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_value(cdb_value),
        .cdb_npc(cdb_npc), .cdb_taken(cdb_taken)
    );

    cdb_complete_arbiter #(.NUM_FU(NF), .CDB_W(1), .TAG_W(TW)) dut1 (
        .clock(clock), .reset(reset), .clear(clear),
        .fu_valid(fu_valid), .fu_tag(fu_tag), .fu_result(fu_result),
        .fu_npc(fu_npc), .fu_taken(fu_taken), .fu_ready(fu_ready_1),
        .cdb_valid(cdb_valid_1), .cdb_tag(cdb_tag_1), .cdb_value(cdb_value_1),
        .cdb_npc(cdb_npc_1), .cdb_taken(cdb_taken_1)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic set_fu(input int i, input logic v, input logic [TW-1:0] t,
                          input logic [XW-1:0] r, input logic [XW-1:0] n, input logic tk);
        fu_valid[i]          = v;
        fu_tag[i*TW +: TW]   = t;
        fu_result[i*XW +: XW] = r;
        fu_npc[i*XW +: XW]   = n;
        fu_taken[i]          = tk;
    endtask

    task automatic reset_pulse();
        reset = 1'b0;
        #2;
        reset = 1'b1;
        tick();
    endtask

    initial begin
        reset = 1'b0;
        clear = 1'b0;
        fu_valid = '0; fu_tag = '0; fu_result = '0; fu_npc = '0; fu_taken = '0;
        #12;
        check("reset_cdb_valid", 64'(cdb_valid), 64'h0);
        check("reset_cdb_tag", 64'(cdb_tag), 64'h0);
        check("reset_fu_ready", 64'(fu_ready), 64'hF);
        reset = 1'b1;
        tick();

        // Single result: accepted at edge 1, held, broadcast after edge 2.
        set_fu(0, 1'b1, 5'd5, 32'h1234, 32'h40, 1'b1);
        #1;
        check("single_ready_in", 64'(fu_ready[0]), 64'h1);
        tick();
        fu_valid = '0;
        #1;
        check("single_lat_not_yet", 64'(cdb_valid), 64'h0);
        check("single_ready_held", 64'(fu_ready[0]), 64'h1);
        tick();
        check("single_valid", 64'(cdb_valid), 64'h1);
        check("single_tag", 64'(cdb_tag[TW-1:0]), 64'd5);
        check("single_value", 64'(cdb_value[XW-1:0]), 64'h1234);
        check("single_npc", 64'(cdb_npc[XW-1:0]), 64'h40);
        check("single_taken", 64'(cdb_taken[0]), 64'h1);
        tick();
        check("single_done", 64'(cdb_valid), 64'h0);

        // Oversubscription from rr_ptr=0.
        reset_pulse();
        for (int i = 0; i < NF; i++) set_fu(i, 1'b1, TW'(i + 1), XW'(32'h100 + i), 32'h0, 1'b0);
        tick();
        fu_valid = '0;
        #1;
        check("over_ready", 64'(fu_ready), 64'h3);
        tick();
        check("over_a_valid", 64'(cdb_valid), 64'h3);
        check("over_a_tag0", 64'(cdb_tag[TW-1:0]), 64'd1);
        check("over_a_tag1", 64'(cdb_tag[2*TW-1:TW]), 64'd2);
        check("over_a_value1", 64'(cdb_value[2*XW-1:XW]), 64'h101);
        tick();
        check("over_b_valid", 64'(cdb_valid), 64'h3);
        check("over_b_tag0", 64'(cdb_tag[TW-1:0]), 64'd3);
        check("over_b_tag1", 64'(cdb_tag[2*TW-1:TW]), 64'd4);
        tick();
        check("over_done", 64'(cdb_valid), 64'h0);

        // Back-pressure: rr_ptr back at 0; FU2's held tag 7 loses to FU0/FU1.
        set_fu(0, 1'b1, 5'd10, 32'hA, 32'h0, 1'b0);
        set_fu(1, 1'b1, 5'd11, 32'hB, 32'h0, 1'b0);
        set_fu(2, 1'b1, 5'd7,  32'h7, 32'h0, 1'b0);
        tick();
        fu_valid = '0;
        set_fu(2, 1'b1, 5'd8, 32'h8, 32'h0, 1'b0);
        #1;
        check("bp_ready_blocked", 64'(fu_ready), 64'hB);
        tick();
        check("bp_first_tags", 64'(cdb_tag), 64'({5'd11, 5'd10}));
        check("bp_ready_granted", 64'(fu_ready[2]), 64'h1);
        tick();
        fu_valid = '0;
        check("bp_tag7_valid", 64'(cdb_valid), 64'h1);
        check("bp_tag7", 64'(cdb_tag[TW-1:0]), 64'd7);
        tick();
        check("bp_tag8_valid", 64'(cdb_valid), 64'h1);
        check("bp_tag8", 64'(cdb_tag[TW-1:0]), 64'd8);

        // Clear with three held entries; rr_ptr is 3 and must survive.
        set_fu(0, 1'b1, 5'd20, 32'h20, 32'h0, 1'b0);
        set_fu(1, 1'b1, 5'd21, 32'h21, 32'h0, 1'b0);
        set_fu(2, 1'b1, 5'd22, 32'h22, 32'h0, 1'b0);
        tick();
        fu_valid = '0;
        clear = 1'b1;
        #1;
        check("clear_ready", 64'(fu_ready), 64'h0);
        tick();
        check("clear_cdb_valid", 64'(cdb_valid), 64'h0);
        clear = 1'b0;
        #1;
        check("clear_after_ready", 64'(fu_ready), 64'hF);
        for (int i = 0; i < NF; i++) set_fu(i, 1'b1, TW'(30 + i), XW'(32'h30 + i), 32'h0, 1'b0);
        tick();
        fu_valid = '0;
        check("clear_hold_empty", 64'(cdb_valid), 64'h0);
        tick();
        check("clear_rr_kept", 64'(cdb_tag), 64'({5'd30, 5'd33}));
        tick();
        check("clear_rest", 64'(cdb_tag), 64'({5'd32, 5'd31}));
        check("clear_rest_valid", 64'(cdb_valid), 64'h3);

        // Asynchronous reset while slots are broadcasting.
        #2;
        reset = 1'b0;
        #1;
        check("areset_valid", 64'(cdb_valid), 64'h0);
        check("areset_tag", 64'(cdb_tag), 64'h0);
        check("areset_value", 64'(cdb_value), 64'h0);
        #3;
        reset = 1'b1;
        set_fu(1, 1'b1, 5'd9, 32'h99, 32'h44, 1'b0);
        tick();
        fu_valid = '0;
        check("areset_lat_not_yet", 64'(cdb_valid), 64'h0);
        tick();
        check("areset_fresh_valid", 64'(cdb_valid), 64'h1);
        check("areset_fresh_tag", 64'(cdb_tag[TW-1:0]), 64'd9);
        check("areset_fresh_value", 64'(cdb_value[XW-1:0]), 64'h99);

        // Fairness on the single-slot instance: FU0 and FU3 always valid.
        reset_pulse();
        set_fu(0, 1'b1, 5'd12, 32'hC, 32'h0, 1'b0);
        set_fu(3, 1'b1, 5'd13, 32'hD, 32'h0, 1'b0);
        tick();
        for (int c = 0; c < 4; c++) begin
            tick();
            check($sformatf("fair_valid_%0d", c), 64'(cdb_valid_1), 64'h1);
            check($sformatf("fair_tag_%0d", c), 64'(cdb_tag_1), (c % 2 == 0) ? 64'd12 : 64'd13);
        end
        fu_valid = '0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cdb_complete_arbiter.md
Name: cdb_complete_arbiter

Overview:
- Complete stage directly downstream of the ALU/MULT functional units.
- Each FU presents one finished result per cycle: ROB tag, value, NPC and branch-taken.
- Results are buffered in one holding entry per FU.
- Up to CDB_W results per cycle are selected round-robin and broadcast on registered CDB slots to the RS, ROB and map table.
- Back-pressure to the FUs is a per-FU ready signal.

Parameters:
- NUM_FU, 4, number of FU result ports (index 0 = lowest).
- CDB_W, 2, number of CDB broadcast slots per cycle (1 ≤ CDB_W ≤ NUM_FU).
- TAG_W, $clog2(`ROBLEN), ROB tag width.

Ports:
- clock  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- clear  in  1  synchronous squash (branch mispredict), active-high.
- fu_valid  in  NUM_FU  FU i presents a result this cycle.
- fu_tag  in  NUM_FU×TAG_W  ROB tag per FU.
- fu_result  in  NUM_FU×`XLEN  result value per FU.
- fu_npc  in  NUM_FU×`XLEN  NPC per FU.
- fu_taken  in  NUM_FU  branch_taken per FU (0 for non-ALU).
- fu_ready  out  NUM_FU  combinational; FU i's result is accepted this cycle.
- cdb_valid  out  CDB_W  slot k broadcasting.
- cdb_tag  out  CDB_W×TAG_W  broadcast tag.
- cdb_value  out  CDB_W×`XLEN  broadcast value.
- cdb_npc  out  CDB_W×`XLEN  broadcast NPC.
- cdb_taken  out  CDB_W  broadcast branch-taken.

Behaviour:
- State:
  - hold_valid[i] plus hold fields per FU.
  - rr_ptr, $clog2(NUM_FU) bits.
  - Registered CDB output slots.
- Reset (async, reset=0): hold_valid=0, rr_ptr=0, cdb_valid=0, all cdb data=0. Reset mid-operation discards everything.
- Candidates: cand[i] = hold_valid[i] (without CDB_BYPASS_EN).
- Grant:
  - Scan cand starting at rr_ptr, ascending and wrapping modulo NUM_FU.
  - The first CDB_W set bits are granted.
  - The j-th grant in scan order drives slot j.
  - Unused slots get cdb_valid=0 next edge; their data is don't-care but held at 0.
- fu_ready[i] = ~clear & (~hold_valid[i] | grant[i]). An entry freed by a grant refills in the same cycle (no bubble).
- Accept: fu_valid[i] & fu_ready[i] loads hold[i] at the next edge. A fu_valid[i] presented while not ready is ignored; the FU must hold its result.
- Grant without new accept clears hold_valid[i].
- rr_ptr update:
  - With at least one grant: (index of last granted FU + 1) mod NUM_FU.
  - With no grants: unchanged.
- Latency (no bypass): accepted in cycle N → in hold at N+1 → earliest cdb_valid in cycle N+2.
- Full: all hold entries valid and none granted → all fu_ready=0; nothing is lost.
- Starvation bound: any held entry is broadcast within ceil(NUM_FU/CDB_W) cycles.
- clear=1:
  - Next edge: hold_valid=0, cdb_valid=0.
  - No accepts that cycle (fu_ready=0).
  - rr_ptr unchanged.
  - clear dominates a simultaneous grant.
- No duplicate-tag checking; the ROB guarantees unique tags.

Optional Feature:
- CDB_BYPASS_EN defined:
  - cand[i] = hold_valid[i] | (fu_valid[i] & ~hold_valid[i]).
  - An incoming result into an empty entry may be granted the same cycle, broadcast at N+1, and is not written to hold.
  - A non-granted incoming result is captured in hold as normal.
  - fu_ready is unchanged.
- CDB_BYPASS_EN undefined: candidates come from hold only, giving 2-cycle latency.

Decomposition:
- sys_defs.svh:
  - CDB_PACKET typedef {valid, tag, value, NPC, taken}.
  - FU_RESULT_PACKET typedef.
  - `NUM_FU and `CDB_W defaults.
- Sub-module rr_multi_select (pure combinational):
  - Inputs: request vector, start pointer.
  - Outputs: grant vector, per-slot one-hot/index, last-granted index.
  - Implementation: rotate, iterative priority pick CDB_W times, un-rotate.

Test Plan:
- Single result: fu_valid[0]=1, tag=5, result=32'h1234, NPC=32'h40, taken=1 at cycle 1 → cdb slot0 valid cycle 3 (cycle 2 with bypass) with those values; fu_ready[0]=1 throughout.
- Oversubscription: all 4 FUs valid with tags 1–4, rr_ptr=0, held → cycle A broadcasts tags 1,2; next cycle 3,4; rr_ptr ends at 0; no result lost.
- Back-pressure: FU2 holds tag 7 ungranted while FU2 offers tag 8 → fu_ready[2]=0. Tag 8 is accepted in the cycle tag 7 is granted, and broadcast one cycle later.
- Fairness: FU0 and FU3 valid every cycle, CDB_W=1 → broadcasts alternate 0,3,0,3; neither waits more than 2 cycles.
- Clear: clear=1 while 3 entries are held → next cycle cdb_valid=0, hold empty, fu_ready=0 during the clear cycle; rr_ptr preserved.
- Async reset: drop reset mid-broadcast, off a clock edge → outputs go to 0 immediately; after release, the first broadcast follows the latency rule from a fresh accept.
